// File: rtl/arm_rf_pkg.sv
// Shared types and constants for the ARM banked register file.
// Physical map: 0-14 USR R0-R14, 15-21 FIQ R8-R14, 22/23 IRQ, 24/25 SVC,
// 26/27 ABT, 28/29 UND R13-R14, 30 = PC (held outside the GPR array).
package arm_rf_pkg;

    typedef enum logic [2:0] {
        BANK_USR = 3'd0,
        BANK_FIQ = 3'd1,
        BANK_IRQ = 3'd2,
        BANK_SVC = 3'd3,
        BANK_ABT = 3'd4,
        BANK_UND = 3'd5
    } bank_e;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

    localparam int         NUM_PHYS = 31;
    localparam logic [4:0] PHYS_PC  = 5'd30;

    // Map (bank, architectural reg) to a physical slot.
    function automatic logic [4:0] phys_idx(input bank_e bank, input logic [3:0] r);
        logic [4:0] r5;
        r5       = {1'b0, r};
        phys_idx = r5;
        if (r == 4'd15) begin
            phys_idx = PHYS_PC;
        end else if (bank == BANK_FIQ && r >= 4'd8) begin
            phys_idx = r5 + 5'd7;
        end else if (r >= 4'd13) begin
            case (bank)
                BANK_IRQ: phys_idx = r5 + 5'd9;
                BANK_SVC: phys_idx = r5 + 5'd11;
                BANK_ABT: phys_idx = r5 + 5'd13;
                BANK_UND: phys_idx = r5 + 5'd15;
                default:  phys_idx = r5;
            endcase
        end
    endfunction

endpackage

// File: rtl/arm_banked_reg_file_if.sv
// Decode/writeback-side bus of the banked register file.
interface arm_banked_reg_file_if #(
    parameter int DATA_W = 32,
    parameter int NUM_RD = 4
);
    logic [4:0]               mode;
    logic                     usr_view;
    logic [NUM_RD*4-1:0]      rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wr0_en;
    logic [3:0]               wr0_addr;
    logic [DATA_W-1:0]        wr0_data;
    logic                     wr1_en;
    logic [3:0]               wr1_addr;
    logic [DATA_W-1:0]        wr1_data;
    logic                     pc_en;
    logic                     pc_load;
    logic [DATA_W-1:0]        pc_update;
    logic [DATA_W-1:0]        pc;
    logic                     pc_changed;
    logic                     mode_err;

    modport master (
        output mode, usr_view, rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, pc_en, pc_load, pc_update,
        input  rd_data, pc, pc_changed, mode_err
    );

    modport slave (
        input  mode, usr_view, rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data, pc_en, pc_load, pc_update,
        output rd_data, pc, pc_changed, mode_err
    );
endinterface

// File: rtl/arm_mode_decode.sv
// CPSR mode bits -> register bank; SYS and illegal modes use the USR bank.
module arm_mode_decode
    import arm_rf_pkg::*;
(
    input  logic [4:0] mode,
    input  logic       usr_view,
    output bank_e      bank,
    output logic       mode_err
);

    // Decode mode; usr_view (LDM/STM ^) forces the USR bank regardless.
    always_comb begin
        bank     = BANK_USR;
        mode_err = 1'b0;
        case (mode)
            MODE_USR: bank = BANK_USR;
            MODE_SYS: bank = BANK_USR;
            MODE_FIQ: bank = BANK_FIQ;
            MODE_IRQ: bank = BANK_IRQ;
            MODE_SVC: bank = BANK_SVC;
            MODE_ABT: bank = BANK_ABT;
            MODE_UND: bank = BANK_UND;
            default:  mode_err = 1'b1;
        endcase
        if (usr_view) bank = BANK_USR;
    end

endmodule

// File: rtl/arm_banked_reg_file.sv
// ARM mode-banked register file with owned PC.
// Optional: define REG_BYPASS_EN to forward same-cycle write data to reads.
module arm_banked_reg_file
    import arm_rf_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                NUM_RD    = 4,
    parameter int                PC_RD_OFS = 8,
    parameter int                PC_INC    = 4,
    parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
    input logic                   clk,
    input logic                   rst_n,
    arm_banked_reg_file_if.slave  bus
);

    localparam logic [DATA_W-1:0] PC_OFS  = DATA_W'(PC_RD_OFS);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

    bank_e             bank;
    logic              mode_err_c;
    logic [DATA_W-1:0] regs [NUM_PHYS-1];
    logic [DATA_W-1:0] pc_q, pc_next;
    logic              pc_chg_q, pc_nonseq;
    logic [4:0]        wr0_idx, wr1_idx;
    logic              wr0_gpr, wr1_gpr, wr0_pc, wr1_pc;

    arm_mode_decode u_dec (
        .mode     (bus.mode),
        .usr_view (bus.usr_view),
        .bank     (bank),
        .mode_err (mode_err_c)
    );

    // Writes share the read bank: the mode present at the edge selects it.
    assign wr0_idx = phys_idx(bank, bus.wr0_addr);
    assign wr1_idx = phys_idx(bank, bus.wr1_addr);
    assign wr0_pc  = bus.wr0_en && (bus.wr0_addr == 4'd15);
    assign wr1_pc  = bus.wr1_en && (bus.wr1_addr == 4'd15);
    assign wr0_gpr = bus.wr0_en && (bus.wr0_addr != 4'd15);
    assign wr1_gpr = bus.wr1_en && (bus.wr1_addr != 4'd15);

    // PC next value: load > wr0 R15 > wr1 R15 > increment > hold.
    always_comb begin
        pc_next   = pc_q;
        pc_nonseq = 1'b0;
        if (bus.pc_load) begin
            pc_next   = bus.pc_update;
            pc_nonseq = 1'b1;
        end else if (wr0_pc) begin
            pc_next   = {bus.wr0_data[DATA_W-1:2], 2'b00};
            pc_nonseq = 1'b1;
        end else if (wr1_pc) begin
            pc_next   = {bus.wr1_data[DATA_W-1:2], 2'b00};
            pc_nonseq = 1'b1;
        end else if (bus.pc_en) begin
            pc_next   = pc_q + PC_STEP;
        end
    end

    // GPR array; wr1 applied first so wr0 wins a same-slot collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PHYS - 1; k++) regs[k] <= '0;
        end else begin
            if (wr1_gpr) regs[wr1_idx] <= bus.wr1_data;
            if (wr0_gpr) regs[wr0_idx] <= bus.wr0_data;
        end
    end

    // PC and its non-sequential-change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            pc_chg_q <= 1'b0;
        end else begin
            pc_q     <= pc_next;
            pc_chg_q <= pc_nonseq;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [3:0]        ra;
        logic [4:0]        ridx;
        logic [DATA_W-1:0] rv;

        assign ra   = bus.rd_addr[4*i +: 4];
        assign ridx = phys_idx(bank, ra);

        // Read mux: R15 returns the pipeline-offset PC, others the banked slot.
        always_comb begin
            if (ra == 4'd15) rv = pc_q + PC_OFS;
            else             rv = regs[ridx];
`ifdef REG_BYPASS_EN
            if (ra == 4'd15) begin
                if (pc_nonseq) rv = pc_next + PC_OFS;
            end else if (wr0_gpr && wr0_idx == ridx) begin
                rv = bus.wr0_data;
            end else if (wr1_gpr && wr1_idx == ridx) begin
                rv = bus.wr1_data;
            end
`endif
        end

        assign bus.rd_data[DATA_W*i +: DATA_W] = rv;
    end

    assign bus.pc         = pc_q;
    assign bus.pc_changed = pc_chg_q;
    assign bus.mode_err   = mode_err_c;

endmodule

// File: tb/tb_arm_banked_reg_file.sv
// Self-checking bench for arm_banked_reg_file: vector table, hand sequences,
// then randomized traffic against a per-bank behavioural model.
module tb_arm_banked_reg_file;

    localparam int DW = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    arm_banked_reg_file_if #(.DATA_W(DW), .NUM_RD(NR)) bus ();

    arm_banked_reg_file #(
        .DATA_W(DW), .NUM_RD(NR), .PC_RD_OFS(8), .PC_INC(4), .RESET_PC(32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.mode = 5'b10000; bus.usr_view = 1'b0; bus.rd_addr = '0;
        bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.pc_en = 1'b0; bus.pc_load = 1'b0; bus.pc_update = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdp(input int i);
        return bus.rd_data[32*i +: 32];
    endfunction

    // Read address r on every port and compare all ports.
    task automatic rd_chk(input string nm, input logic [3:0] r, input logic [31:0] exp);
        bus.rd_addr = {NR{r}};
        #1;
        for (int p = 0; p < NR; p++) chk(nm, rdp(p), exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_usr [15];
    logic [31:0] m_fiq [7];
    logic [31:0] m_bk  [6][2];
    logic [31:0] m_pc, m_nxt;
    bit          m_chg, m_nonseq;

    function automatic int mb(input logic [4:0] m, input bit uv);
        if (uv) return 0;
        case (m)
            5'b10001: return 1;
            5'b10010: return 2;
            5'b10011: return 3;
            5'b10111: return 4;
            5'b11011: return 5;
            default:  return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [4:0] m);
        return m inside {5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10111, 5'b11011, 5'b11111};
    endfunction

    function automatic logic [31:0] mread(input int b, input int r);
        if (r == 15)             return m_pc + 32'd8;
        if (b == 1 && r >= 8)    return m_fiq[r-8];
        if (b >= 2 && r >= 13)   return m_bk[b][r-13];
        return m_usr[r];
    endfunction

    task automatic mwrite(input int b, input int r, input logic [31:0] d);
        if (b == 1 && r >= 8)       m_fiq[r-8] = d;
        else if (b >= 2 && r >= 13) m_bk[b][r-13] = d;
        else                        m_usr[r] = d;
    endtask

    function automatic logic [31:0] mexp_rd(input int b, input int r);
`ifdef REG_BYPASS_EN
        if (r == 15 && m_nonseq) return m_nxt + 32'd8;
        if (r != 15 && bus.wr0_en && int'(bus.wr0_addr) == r) return bus.wr0_data;
        if (r != 15 && bus.wr1_en && int'(bus.wr1_addr) == r) return bus.wr1_data;
`endif
        return mread(b, r);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  mode;
        bit          uv;
        bit          w0;
        logic [3:0]  a0;
        logic [31:0] d0;
        bit          w1;
        logic [3:0]  a1;
        logic [31:0] d1;
        logic [3:0]  ra;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [16];

    initial begin
        logic [4:0] modes [7];
        logic [31:0] exp_v;
        int b;

        modes = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10111, 5'b11011, 5'b11111};

        tbl[0]  = '{5'b10000, 0, 1, 4'd8,  32'h11,   0, 4'd0,  32'h0,    4'd0,  32'h0,    0};
        tbl[1]  = '{5'b10001, 0, 1, 4'd8,  32'h22,   0, 4'd0,  32'h0,    4'd7,  32'h0,    0};
        tbl[2]  = '{5'b10000, 0, 1, 4'd7,  32'h77,   0, 4'd0,  32'h0,    4'd8,  32'h11,   0};
        tbl[3]  = '{5'b10001, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd8,  32'h22,   0};
        tbl[4]  = '{5'b10001, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd7,  32'h77,   0};
        tbl[5]  = '{5'b10011, 0, 1, 4'd13, 32'hABC,  0, 4'd0,  32'h0,    4'd14, 32'h0,    0};
        tbl[6]  = '{5'b10011, 1, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd13, 32'h0,    0};
        tbl[7]  = '{5'b10011, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd13, 32'hABC,  0};
        tbl[8]  = '{5'b00000, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd13, 32'h0,    1};
        tbl[9]  = '{5'b10000, 0, 1, 4'd3,  32'h5,    1, 4'd3,  32'h9,    4'd0,  32'h0,    0};
        tbl[10] = '{5'b10000, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd3,  32'h5,    0};
        tbl[11] = '{5'b10010, 0, 0, 4'd0,  32'h0,    1, 4'd14, 32'h1234, 4'd13, 32'h0,    0};
        tbl[12] = '{5'b10010, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd14, 32'h1234, 0};
        tbl[13] = '{5'b10000, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd14, 32'h0,    0};
        tbl[14] = '{5'b11111, 0, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd8,  32'h11,   0};
        tbl[15] = '{5'b10001, 1, 0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    4'd8,  32'h11,   0};

        // Reset state
        idle();
        #12 rst_n = 1'b1;
        #1;
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_pc_changed", {31'b0, bus.pc_changed}, 32'h0);
        rd_chk("reset_r0", 4'd0, 32'h0);
        rd_chk("reset_r15", 4'd15, 32'h8);
        tick();

        // Table-driven banking / collision vectors
        foreach (tbl[i]) begin
            bus.mode = tbl[i].mode; bus.usr_view = tbl[i].uv;
            bus.wr0_en = tbl[i].w0; bus.wr0_addr = tbl[i].a0; bus.wr0_data = tbl[i].d0;
            bus.wr1_en = tbl[i].w1; bus.wr1_addr = tbl[i].a1; bus.wr1_data = tbl[i].d1;
            rd_chk($sformatf("tbl%0d_rd", i), tbl[i].ra, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_err", i), {31'b0, bus.mode_err}, {31'b0, tbl[i].exp_err});
            tick();
            idle();
        end

        // PC sequencing
        bus.pc_load = 1'b1; bus.pc_update = 32'h100;
        tick(); idle();
        chk("pc_load_100", bus.pc, 32'h100);
        chk("pc_chg_load", {31'b0, bus.pc_changed}, 32'h1);
        rd_chk("r15_108", 4'd15, 32'h108);
        bus.pc_en = 1'b1;
        tick(); bus.pc_en = 1'b0;
        chk("pc_chg_seq", {31'b0, bus.pc_changed}, 32'h0);
        rd_chk("r15_10c", 4'd15, 32'h10C);
        bus.pc_load = 1'b1; bus.pc_update = 32'h18;
        bus.wr0_en = 1'b1; bus.wr0_addr = 4'd15; bus.wr0_data = 32'h40;
        tick(); idle();
        chk("pc_load_over_wr", bus.pc, 32'h18);
        chk("pc_chg_pulse", {31'b0, bus.pc_changed}, 32'h1);
        tick();
        chk("pc_chg_drop", {31'b0, bus.pc_changed}, 32'h0);
        chk("pc_hold", bus.pc, 32'h18);
        bus.wr1_en = 1'b1; bus.wr1_addr = 4'd15; bus.wr1_data = 32'h103;
        tick(); idle();
        chk("pc_wr1_align", bus.pc, 32'h100);
        bus.wr0_en = 1'b1; bus.wr0_addr = 4'd15; bus.wr0_data = 32'h202;
        bus.wr1_en = 1'b1; bus.wr1_addr = 4'd15; bus.wr1_data = 32'h300;
        tick(); idle();
        chk("pc_wr0_over_wr1", bus.pc, 32'h200);
        bus.pc_load = 1'b1; bus.pc_update = 32'hFFFF_FFFC;
        tick(); idle();
        bus.pc_en = 1'b1;
        tick(); idle();
        chk("pc_wrap", bus.pc, 32'h0);
        chk("pc_wrap_chg", {31'b0, bus.pc_changed}, 32'h0);

        // Same-cycle read of a reg being written
        bus.wr0_en = 1'b1; bus.wr0_addr = 4'd2; bus.wr0_data = 32'h33;
        tick(); idle();
        bus.wr0_en = 1'b1; bus.wr0_addr = 4'd2; bus.wr0_data = 32'h77;
`ifdef REG_BYPASS_EN
        rd_chk("same_cycle_r2", 4'd2, 32'h77);
`else
        rd_chk("same_cycle_r2", 4'd2, 32'h33);
`endif
        tick(); idle();
        rd_chk("after_r2", 4'd2, 32'h77);

        // Mid-run reset with a write in flight
        bus.wr0_en = 1'b1; bus.wr0_addr = 4'd4; bus.wr0_data = 32'h55;
        bus.pc_load = 1'b1; bus.pc_update = 32'h400;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", bus.pc, 32'h0);
        tick();
        bus.pc_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_pc_changed", {31'b0, bus.pc_changed}, 32'h0);
        rd_chk("rst_r3", 4'd3, 32'h0);
        rd_chk("rst_r7", 4'd7, 32'h0);
        bus.mode = 5'b10001;
        rd_chk("rst_fiq_r8", 4'd8, 32'h0);
        bus.mode = 5'b10000;
        tick(); idle();
        rd_chk("post_rst_write", 4'd4, 32'h55);

        // Randomized traffic vs model: reset both sides first
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        foreach (m_usr[i]) m_usr[i] = '0;
        foreach (m_fiq[i]) m_fiq[i] = '0;
        for (int i = 0; i < 6; i++) begin m_bk[i][0] = '0; m_bk[i][1] = '0; end
        m_pc = '0; m_chg = 0;
        @(negedge clk);

        for (int it = 0; it < 400; it++) begin
            bus.mode      = ($urandom_range(0, 9) == 0) ? 5'($urandom) : modes[$urandom_range(0, 6)];
            bus.usr_view  = ($urandom_range(0, 5) == 0);
            bus.rd_addr   = NR*4'($urandom);
            bus.wr0_en    = $urandom_range(0, 1) == 1;
            bus.wr0_addr  = 4'($urandom);
            bus.wr0_data  = $urandom;
            bus.wr1_en    = $urandom_range(0, 2) == 0;
            bus.wr1_addr  = ($urandom_range(0, 3) == 0) ? bus.wr0_addr : 4'($urandom);
            bus.wr1_data  = $urandom;
            bus.pc_en     = $urandom_range(0, 1) == 1;
            bus.pc_load   = $urandom_range(0, 9) == 0;
            bus.pc_update = $urandom;

            b = mb(bus.mode, bus.usr_view);
            m_nonseq = 1; m_nxt = m_pc;
            if (bus.pc_load)                               m_nxt = bus.pc_update;
            else if (bus.wr0_en && bus.wr0_addr == 4'd15)  m_nxt = bus.wr0_data & ~32'h3;
            else if (bus.wr1_en && bus.wr1_addr == 4'd15)  m_nxt = bus.wr1_data & ~32'h3;
            else begin
                m_nonseq = 0;
                if (bus.pc_en) m_nxt = m_pc + 32'd4;
            end

            #1;
            for (int p = 0; p < NR; p++) begin
                exp_v = mexp_rd(b, int'(bus.rd_addr[4*p +: 4]));
                chk($sformatf("rnd%0d_rd%0d", it, p), rdp(p), exp_v);
            end
            chk($sformatf("rnd%0d_err", it), {31'b0, bus.mode_err}, {31'b0, !legal(bus.mode)});
            chk($sformatf("rnd%0d_pc", it), bus.pc, m_pc);
            chk($sformatf("rnd%0d_chg", it), {31'b0, bus.pc_changed}, {31'b0, m_chg});

            if (bus.wr1_en && bus.wr1_addr != 4'd15) mwrite(b, int'(bus.wr1_addr), bus.wr1_data);
            if (bus.wr0_en && bus.wr0_addr != 4'd15) mwrite(b, int'(bus.wr0_addr), bus.wr0_data);
            m_pc  = m_nxt;
            m_chg = m_nonseq;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
